// File: rtl/steer_cond_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : steer_cond_gen_if
// Description : Sample/condition bundle between the load-cell front end, the
//               condition generator and the steering-enable state machine.
//               master : drives samples and the timer clear, observes flags
//                        (front end / steering-enable FSM side)
//               slave  : receives samples and clear, produces flags
//                        (steer_cond_gen)
//   lft_ld, rght_ld : 12-bit unsigned load-cell samples
//   ld_vld          : one-cycle strobe qualifying the samples
//   clr_tmr         : settle-timer clear
//   sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16 : condition flags
//   tmr_full        : settle timer at terminal count
//   cond_vld        : one-cycle pulse when the flags update
//   ld_stale        : no sample seen for the watchdog period
// Revision    : 1.0 - initial release
// ============================================================================
interface steer_cond_gen_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        ld_vld;
  logic        clr_tmr;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        tmr_full;
  logic        cond_vld;
  logic        ld_stale;

  modport master (
    output lft_ld, rght_ld, ld_vld, clr_tmr,
    input  sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16,
    input  tmr_full, cond_vld, ld_stale
  );

  modport slave (
    input  lft_ld, rght_ld, ld_vld, clr_tmr,
    output sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16,
    output tmr_full, cond_vld, ld_stale
  );
endinterface
`default_nettype wire

// File: rtl/steer_cond_gen.sv
`default_nettype none
// ============================================================================
// Module      : steer_cond_gen
// Description : Rider condition generator for the steering-enable logic.
//               Captures left/right load-cell samples, derives rider-presence
//               (sum with hysteresis band) and rider-balance (|diff| vs sum
//               fractions) flags through a 3-stage pipeline, runs the settle
//               timer and a sample-stale watchdog that forces a rider-off
//               indication when samples stop arriving.
// Ports       : clk  - system clock (50 MHz)
//               rst  - synchronous active-high reset
//               bus  - steer_cond_gen_if.slave (samples in, flags out)
// Options     : STEER_FAST_SIM_EN - when defined, the settle timer terminal
//               count uses only counter bits [14:0] (32767 cycles) so that
//               simulations stay short.
// Revision    : 1.0 - initial release
// ============================================================================
module steer_cond_gen #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] HYST         = 12'h040,
  parameter logic [15:0] STALE_CYC    = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  steer_cond_gen_if.slave    bus
);

  // Thresholds are formed in 13 bits so they compare directly with the sum.
  localparam logic [12:0] C_GT_THR     = {1'b0, MIN_RIDER_WT} + {1'b0, HYST};
  localparam logic [12:0] C_LT_THR     = {1'b0, MIN_RIDER_WT} - {1'b0, HYST};
  localparam logic [15:0] C_STALE_LAST = STALE_CYC - 16'd1;

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic        r_s1_vld;
  logic [11:0] r_s1_lft;
  logic [11:0] r_s1_rght;

  logic        r_s2_vld;
  logic [12:0] r_s2_sum;
  logic [11:0] r_s2_diff;

  logic        r_sum_gt_min;
  logic        r_sum_lt_min;
  logic        r_diff_gt_1_4;
  logic        r_diff_gt_15_16;
  logic        r_cond_vld;

  // Watchdog and timer state
  logic [15:0] r_stale_cnt;
  logic        r_ld_stale;
  logic [25:0] r_tmr;

  // --------------------------------------------------------------------------
  // S2 arithmetic (combinational from S1 registers)
  // --------------------------------------------------------------------------
  logic [12:0] w_sum;
  logic [12:0] w_sdiff;
  logic [12:0] w_sdiff_neg;
  logic [12:0] w_mag;
  logic [11:0] w_diff;
  logic        w_unused_mag_msb;

  assign w_sum       = {1'b0, r_s1_lft} + {1'b0, r_s1_rght};
  assign w_sdiff     = {1'b0, r_s1_lft} - {1'b0, r_s1_rght};
  assign w_sdiff_neg = 13'd0 - w_sdiff;
  // Bit 12 of the signed difference is its sign; the magnitude of a
  // difference of two 12-bit unsigned values always fits in 12 bits.
  assign w_mag            = w_sdiff[12] ? w_sdiff_neg : w_sdiff;
  assign w_diff           = w_mag[11:0];
  assign w_unused_mag_msb = w_mag[12];

  // --------------------------------------------------------------------------
  // S3 comparisons (combinational from S2 registers)
  // --------------------------------------------------------------------------
  logic w_gt_min;
  logic w_lt_min;
  logic w_gt_1_4;
  logic w_gt_15_16;

  assign w_gt_min   = (r_s2_sum > C_GT_THR);
  assign w_lt_min   = (r_s2_sum < C_LT_THR);
  assign w_gt_1_4   = ({1'b0, r_s2_diff} > (r_s2_sum >> 2));
  assign w_gt_15_16 = ({1'b0, r_s2_diff} > (r_s2_sum - (r_s2_sum >> 4)));

  // Watchdog reaches its threshold on a cycle with no sample. The counter
  // then holds at the threshold so this term stays true until a sample
  // arrives, which keeps the forced rider-off values in place.
  logic w_stale_set;
  assign w_stale_set = !bus.ld_vld && (r_stale_cnt == C_STALE_LAST);

  // --------------------------------------------------------------------------
  // S1 / S2 pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_lft  <= 12'd0;
      r_s1_rght <= 12'd0;
      r_s2_vld  <= 1'b0;
      r_s2_sum  <= 13'd0;
      r_s2_diff <= 12'd0;
    end else begin
      r_s1_vld <= bus.ld_vld;
      if (bus.ld_vld) begin
        r_s1_lft  <= bus.lft_ld;
        r_s1_rght <= bus.rght_ld;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sum  <= w_sum;
        r_s2_diff <= w_diff;
      end
    end
  end

  // --------------------------------------------------------------------------
  // S3 flag registers
  // --------------------------------------------------------------------------
  // A stale condition overrides any update and loads the fail-safe rider-off
  // pattern; the flags then hold it until the next sample reaches S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum_gt_min    <= 1'b0;
      r_sum_lt_min    <= 1'b1;
      r_diff_gt_1_4   <= 1'b0;
      r_diff_gt_15_16 <= 1'b0;
      r_cond_vld      <= 1'b0;
    end else begin
      r_cond_vld <= r_s2_vld;
      if (w_stale_set) begin
        r_sum_gt_min    <= 1'b0;
        r_sum_lt_min    <= 1'b1;
        r_diff_gt_1_4   <= 1'b0;
        r_diff_gt_15_16 <= 1'b0;
      end else if (r_s2_vld) begin
        r_sum_gt_min    <= w_gt_min;
        r_sum_lt_min    <= w_lt_min;
        r_diff_gt_1_4   <= w_gt_1_4;
        r_diff_gt_15_16 <= w_gt_15_16;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stale watchdog
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stale_cnt <= 16'd0;
      r_ld_stale  <= 1'b0;
    end else if (bus.ld_vld) begin
      r_stale_cnt <= 16'd0;
      r_ld_stale  <= 1'b0;
    end else if (w_stale_set) begin
      r_ld_stale  <= 1'b1;
    end else begin
      r_stale_cnt <= r_stale_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Settle timer
  // --------------------------------------------------------------------------
  logic w_tmr_term;

`ifdef STEER_FAST_SIM_EN
  // Shortened terminal count: only the low 15 bits are observed and the
  // counter stops there, so the upper bits stay at zero.
  assign w_tmr_term = &r_tmr[14:0];
`else
  assign w_tmr_term = &r_tmr;
`endif

  // Clear has priority over both increment and saturation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr <= 26'd0;
    end else if (bus.clr_tmr) begin
      r_tmr <= 26'd0;
    end else if (!w_tmr_term) begin
      r_tmr <= r_tmr + 26'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.sum_gt_min    = r_sum_gt_min;
  assign bus.sum_lt_min    = r_sum_lt_min;
  assign bus.diff_gt_1_4   = r_diff_gt_1_4;
  assign bus.diff_gt_15_16 = r_diff_gt_15_16;
  assign bus.cond_vld      = r_cond_vld;
  assign bus.ld_stale      = r_ld_stale;
  assign bus.tmr_full      = w_tmr_term;

endmodule
`default_nettype wire

// File: tb/tb_steer_cond_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_steer_cond_gen
// Description : Self-checking bench for steer_cond_gen. An event-level model
//               (sample results due three cycles after their strobe, stale
//               and timer state derived from cycle distances to the last
//               sample / clear) is compared with the DUT every cycle, and
//               directed vectors carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_steer_cond_gen;

  localparam int GT_THR = 'h240;   // 0x200 + 0x040
  localparam int LT_THR = 'h1C0;   // 0x200 - 0x040
  localparam int STALE  = 50000;
`ifdef STEER_FAST_SIM_EN
  localparam longint TERM    = 32767;
  localparam logic   SAT_EXP = 1'b1;
`else
  localparam longint TERM    = 67108863;
  localparam logic   SAT_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  steer_cond_gen_if bus ();

  steer_cond_gen #(
    .MIN_RIDER_WT (12'h200),
    .HYST         (12'h040),
    .STALE_CYC    (16'd50000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    int   due;
    logic gt, lt, d14, d1516;
  } ev_t;

  ev_t  q[$];
  bit   m_valid = 1'b0;
  int   last_l  = 0;     // last cycle with a sample (or reset)
  int   last_c  = 0;     // last cycle with a timer clear (or reset)
  logic m_gt, m_lt, m_d14, m_d1516;

  function automatic ev_t calc(input int l, input int r, input int due);
    ev_t e;
    int  s, d;
    s = l + r;
    d = (l > r) ? (l - r) : (r - l);
    e.due   = due;
    e.gt    = (s > GT_THR);
    e.lt    = (s < LT_THR);
    e.d14   = (4 * d > s);
    e.d1516 = (d > s - s / 16);
    return e;
  endfunction

  initial begin
    ev_t  e;
    logic exp_cond, exp_stale, exp_tmr;
    forever begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        exp_cond = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e        = q.pop_front();
          exp_cond = 1'b1;
          m_gt = e.gt; m_lt = e.lt; m_d14 = e.d14; m_d1516 = e.d1516;
        end
        exp_stale = ((cyc - last_l) > STALE);
        if (exp_stale) begin
          m_gt = 1'b0; m_lt = 1'b1; m_d14 = 1'b0; m_d1516 = 1'b0;
        end
        exp_tmr = (longint'(cyc - last_c - 1) >= TERM);
        chk("mdl_sum_gt_min",    bus.sum_gt_min,    m_gt);
        chk("mdl_sum_lt_min",    bus.sum_lt_min,    m_lt);
        chk("mdl_diff_gt_1_4",   bus.diff_gt_1_4,   m_d14);
        chk("mdl_diff_gt_15_16", bus.diff_gt_15_16, m_d1516);
        chk("mdl_cond_vld",      bus.cond_vld,      exp_cond);
        chk("mdl_ld_stale",      bus.ld_stale,      exp_stale);
        chk("mdl_tmr_full",      bus.tmr_full,      exp_tmr);
      end
      // Record this cycle's inputs for future cycles.
      if (rst) begin
        m_valid = 1'b1;
        last_l  = cyc;
        last_c  = cyc;
        q.delete();
        m_gt = 1'b0; m_lt = 1'b1; m_d14 = 1'b0; m_d1516 = 1'b0;
      end else if (m_valid) begin
        if (bus.ld_vld) begin
          last_l = cyc;
          q.push_back(calc(int'(bus.lft_ld), int'(bus.rght_ld), cyc + 3));
        end
        if (bus.clr_tmr) last_c = cyc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic lit_flags(input string name, input logic gt, input logic lt,
                           input logic d14, input logic d1516, input logic cv);
    chk({name, "_gt"},   bus.sum_gt_min,    gt);
    chk({name, "_lt"},   bus.sum_lt_min,    lt);
    chk({name, "_d14"},  bus.diff_gt_1_4,   d14);
    chk({name, "_d1516"}, bus.diff_gt_15_16, d1516);
    chk({name, "_cv"},   bus.cond_vld,      cv);
  endtask

  // One strobe, then check the flags in the third cycle after it.
  task automatic send_chk(input string name, input logic [11:0] l,
                          input logic [11:0] r, input logic gt, input logic lt,
                          input logic d14, input logic d1516);
    @(posedge clk); #1;
    bus.lft_ld = l; bus.rght_ld = r; bus.ld_vld = 1'b1;
    @(posedge clk); #1;
    bus.ld_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    lit_flags(name, gt, lt, d14, d1516, 1'b1);
  endtask

  logic [11:0] b2b_l [4];
  logic [11:0] b2b_r [4];
  logic [3:0]  b2b_e [4];   // {gt, lt, d14, d1516}

  initial begin
    rst = 1'b1;
    bus.lft_ld = 12'd0; bus.rght_ld = 12'd0;
    bus.ld_vld = 1'b0;  bus.clr_tmr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    lit_flags("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_stale", bus.ld_stale, 1'b0);
    chk("reset_tmr",   bus.tmr_full, 1'b0);

    send_chk("s150",   12'h150, 12'h150, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("s150_cv_once", bus.cond_vld, 1'b0);
    send_chk("band",   12'h100, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    send_chk("low",    12'h0E0, 12'h0D0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_chk("quart",  12'h200, 12'h080, 1'b1, 1'b0, 1'b1, 1'b0);
    send_chk("full",   12'h280, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1);

    // Four back-to-back strobes; results in four consecutive cycles.
    b2b_l[0] = 12'h150; b2b_r[0] = 12'h150; b2b_e[0] = 4'b1000;
    b2b_l[1] = 12'h100; b2b_r[1] = 12'h100; b2b_e[1] = 4'b0000;
    b2b_l[2] = 12'h0E0; b2b_r[2] = 12'h0D0; b2b_e[2] = 4'b0100;
    b2b_l[3] = 12'h000; b2b_r[3] = 12'h280; b2b_e[3] = 4'b1011;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        bus.lft_ld = b2b_l[k]; bus.rght_ld = b2b_r[k]; bus.ld_vld = 1'b1;
      end else begin
        bus.ld_vld = 1'b0;
      end
      @(negedge clk);
      if (k >= 3)
        lit_flags("b2b", b2b_e[k-3][3], b2b_e[k-3][2], b2b_e[k-3][1],
                  b2b_e[k-3][0], 1'b1);
    end
    @(negedge clk);
    chk("b2b_end_cv", bus.cond_vld, 1'b0);

    // Stale watchdog: last strobe is three cycles before the return of
    // send_chk; stale appears 50001 cycles after that strobe.
    send_chk("pre_stale", 12'h150, 12'h150, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (49997) @(posedge clk);
    @(negedge clk);
    chk("stale_edge_minus1", bus.ld_stale, 1'b0);
    chk("stale_edge_gt",     bus.sum_gt_min, 1'b1);
    @(negedge clk);
    chk("stale_set",    bus.ld_stale,   1'b1);
    chk("stale_lt",     bus.sum_lt_min, 1'b1);
    chk("stale_gt",     bus.sum_gt_min, 1'b0);
    chk("tmr_sat_lvl",  bus.tmr_full,   SAT_EXP);

    // Recovery sample: stale clears next cycle, forced flags hold until +3.
    @(posedge clk); #1;
    bus.lft_ld = 12'h150; bus.rght_ld = 12'h150; bus.ld_vld = 1'b1;
    @(posedge clk); #1;
    bus.ld_vld = 1'b0;
    @(negedge clk);
    chk("recov_stale", bus.ld_stale,   1'b0);
    chk("recov_hold",  bus.sum_lt_min, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    lit_flags("recov", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Timer clear with a saturated count (fast build) or running count.
    @(posedge clk); #1;
    bus.clr_tmr = 1'b1;
    @(negedge clk);
    chk("tmr_before_clr", bus.tmr_full, SAT_EXP);
    @(posedge clk); #1;
    bus.clr_tmr = 1'b0;
    @(negedge clk);
    chk("tmr_after_clr", bus.tmr_full, 1'b0);
    repeat (5) @(posedge clk);

    // Reset while a sample sits in S2: it must never produce cond_vld.
    @(posedge clk); #1;
    bus.lft_ld = 12'h0E0; bus.rght_ld = 12'h0D0; bus.ld_vld = 1'b1;
    @(posedge clk); #1;
    bus.ld_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lit_flags("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_stale", bus.ld_stale, 1'b0);
      chk("rst_mid_tmr",   bus.tmr_full, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
